// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the mem_arbiter block.
//   arb_state_e : arbiter FSM state encoding (2 bits)
//   WidthW      : width of the byte-width field passed through to mem
//   wrap_inc    : increment an index modulo a count
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } arb_state_e;

    localparam int unsigned WidthW = 4;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or after ptr,
// wrapping at NUM_REQ.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index that has first priority
//   gnt   out NUM_REQ  one-hot winner (0 if no request)
//   idx   out IDX_W    index of the winner
//   valid out 1        any request present
module mem_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        int unsigned k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem/sram port between NUM_REQ masters, one transaction
// at a time: IDLE (arbitrate) -> ISSUE (RD_LAT+1 cycles on mem) -> RESP (ack) -> IDLE.
// Optional feature: define MEM_ARB_LOCK_EN to add lock_i, letting the current owner keep
// the port across consecutive transactions.
// Ports:
//   clk, rst (sync, active-low)
//   req_i/req_we_i/req_addr_i/req_width_i/req_data_i : packed per-master requests
//   lock_i      : per-master lock request (MEM_ARB_LOCK_EN only)
//   gnt_o/ack_o : one-hot owner and one-cycle completion pulse
//   rdata_o     : read data, nonzero only with ack_o on a read
//   busy_o      : transaction in flight
//   mem_*       : port to mem; all zero outside ISSUE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*WidthW-1:0]   req_width_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock_i,
`endif
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        busy_o,
    output logic                        mem_ce_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [WidthW-1:0]           mem_width_o,
    output logic [DATA_W-1:0]           mem_data_o,
    input  logic [DATA_W-1:0]           mem_data_i
);

    localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0]  LastCnt = 2'(RD_LAT);

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d, g_q, g_d, ptr_next;
    logic [1:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WidthW-1:0]   width_q, width_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                lock_q, lock_d, lock_take, lock_release;

    logic [NUM_REQ-1:0]  pick_req, pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_valid;

`ifdef MEM_ARB_LOCK_EN
    assign lock_take    = lock_i[g_q];
    assign lock_release = lock_q && !lock_i[g_q];
`else
    assign lock_take    = 1'b0;
    assign lock_release = 1'b0;
`endif

    // While locked, ptr_q == g_q and gnt_q is the owner, so masking leaves only the owner.
    assign pick_req = lock_q ? (req_i & gnt_q) : req_i;
    assign ptr_next = IdxW'(wrap_inc(32'(g_q), NUM_REQ));

    mem_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        width_d = width_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
        lock_d  = lock_q;
        unique case (state_q)
            StIdle: begin
                if (lock_release) begin
                    lock_d = 1'b0;
                    ptr_d  = ptr_next;
                    gnt_d  = '0;
                end else if (pick_valid) begin
                    g_d     = pick_idx;
                    gnt_d   = pick_gnt;
                    we_d    = req_we_i[pick_idx];
                    addr_d  = req_addr_i[32'(pick_idx)*ADDR_W +: ADDR_W];
                    width_d = req_width_i[32'(pick_idx)*WidthW +: WidthW];
                    wdata_d = req_data_i[32'(pick_idx)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cnt_q == LastCnt) begin
                    // Writes return zero so a write ack never carries stale read data.
                    rdata_d = we_q ? '0 : mem_data_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (lock_take) begin
                    lock_d = 1'b1;
                    ptr_d  = g_q;
                end else begin
                    ptr_d = ptr_next;
                    gnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic issue, resp;
    assign issue = (state_q == StIssue);
    assign resp  = (state_q == StResp);

    assign gnt_o       = gnt_q;
    assign ack_o       = resp ? gnt_q : '0;
    assign rdata_o     = resp ? rdata_q : '0;
    assign busy_o      = issue || resp;
    assign mem_ce_o    = issue;
    assign mem_we_o    = issue && we_q;
    assign mem_addr_o  = issue ? addr_q : '0;
    assign mem_width_o = issue ? width_q : '0;
    assign mem_data_o  = issue ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  we = '0;
    logic [N*32-1:0] addr = '0;
    logic [N*4-1:0]  width = '0;
    logic [N*32-1:0] wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic [N-1:0]  lock = '0;
`endif
    logic [N-1:0]  gnt_o, ack_o;
    logic [31:0]   rdata_o, mem_addr_o, mem_data_o, mem_data_i;
    logic          busy_o, mem_ce_o, mem_we_o;
    logic [3:0]    mem_width_o;

    int errors = 0;
    int checks = 0;
    int ref_ptr = 0;
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (32),
        .DATA_W  (32),
        .RD_LAT  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .req_we_i    (we),
        .req_addr_i  (addr),
        .req_width_i (width),
        .req_data_i  (wdata),
`ifdef MEM_ARB_LOCK_EN
        .lock_i      (lock),
`endif
        .gnt_o       (gnt_o),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_width_o (mem_width_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

    function automatic logic [31:0] word_init(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0001_0003);
    endfunction

    // Synchronous-read sram, one cycle latency; unwritten words read as word_init().
    logic [31:0] sram [256];
    bit          wr_v [256];
    logic [31:0] rd_q = '0;
    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o) begin
            sram[mem_addr_o[9:2]] <= mem_data_o;
            wr_v[mem_addr_o[9:2]] <= 1'b1;
        end
        if (mem_ce_o && !mem_we_o)
            rd_q <= wr_v[mem_addr_o[9:2]] ? sram[mem_addr_o[9:2]] : word_init(int'(mem_addr_o[9:2]));
    end
    assign mem_data_i = rd_q;

    // Reference round-robin: first pending master at or after ptr.
    function automatic int rr_ref(input logic [N-1:0] p, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (p[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int m, input bit w, input logic [31:0] a, input logic [31:0] d);
        req[m]           = 1'b1;
        we[m]            = w;
        addr[m*32 +: 32] = a;
        wdata[m*32 +: 32] = d;
        width[m*4 +: 4]  = 4'd4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ref_ptr = 0;
    endtask

    // Starts one request from an idle cycle and waits (bounded) for its ack.
    task automatic run_txn(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        @(negedge clk);
        set_req(m, w, a, d);
        lat = -1;
        rd  = 'x;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack_o[m]) begin
                lat = c;
                rd  = rdata_o;
                req[m] = 1'b0;
                break;
            end
        end
        ref_ptr = (m + 1) % N;
        if (w) ref_mem[a[9:2]] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
        checks++; if (ack_o !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        checks++; if (busy_o !== 1'b0 || mem_ce_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: busy=%b ce=%b we=%b want 0", busy_o, mem_ce_o, mem_we_o);
        end
        checks++; if ({rdata_o, mem_addr_o, mem_width_o, mem_data_o} !== '0) begin
            errors++; $display("FAIL reset_data: rdata=%h addr=%h width=%h data=%h want 0",
                               rdata_o, mem_addr_o, mem_width_o, mem_data_o);
        end
        rst = 1'b1;
        ref_ptr = 0;
    endtask

    task automatic test_single_read();
        int ce_cnt = 0, ack_cyc = 0;
        logic [N-1:0] ack_seen = '0;
        logic [31:0] rd = '0;
        @(negedge clk);
        set_req(0, 1'b0, 32'd64, 32'd0);
        for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (gnt_o !== 2'b01 || busy_o !== 1'b1) begin
                    errors++; $display("FAIL single_gnt: gnt=%b busy=%b want 01/1", gnt_o, busy_o);
                end
            end
            if (mem_ce_o) begin
                ce_cnt++;
                checks++; if (mem_addr_o !== 32'd64 || mem_width_o !== 4'd4 || mem_we_o !== 1'b0) begin
                    errors++; $display("FAIL single_mem: addr=%h width=%h we=%b want 40/4/0",
                                       mem_addr_o, mem_width_o, mem_we_o);
                end
            end
            if (ack_o != '0) begin
                ack_cyc = c; ack_seen = ack_o; rd = rdata_o; req[0] = 1'b0;
            end
        end
        ref_ptr = 1;
        checks++; if (ack_cyc != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", ack_cyc); end
        checks++; if (ack_seen !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", ack_seen); end
        checks++; if (ce_cnt != 2) begin errors++; $display("FAIL single_ce_cycles: got %0d want 2", ce_cnt); end
        checks++; if (rd !== ref_mem[16]) begin
            errors++; $display("FAIL single_rdata: got %h want %h", rd, ref_mem[16]);
        end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || gnt_o !== '0 || ack_o !== '0 || rdata_o !== '0) begin
            errors++; $display("FAIL single_idle: busy=%b gnt=%b ack=%b rdata=%h want all 0",
                               busy_o, gnt_o, ack_o, rdata_o);
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] rd;
        int lat;
        run_txn(1, 1'b1, 32'd128, 32'hDEADBEEF, rd, lat);
        checks++; if (lat != 3 || rd !== 32'd0) begin
            errors++; $display("FAIL write_ack: lat=%0d rdata=%h want 3/0", lat, rd);
        end
        run_txn(1, 1'b0, 32'd128, 32'd0, rd, lat);
        checks++; if (lat != 3 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL readback: lat=%0d rdata=%h want 3/deadbeef", lat, rd);
        end
    endtask

    task automatic test_simultaneous();
        int n_ack = 0;
        do_reset();
        set_req(0, 1'b0, 32'd8, 32'd0);
        set_req(1, 1'b0, 32'd12, 32'd0);
        for (int c = 1; c <= 20 && n_ack < 2; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL simul_idle_gnt: got %b want 00", gnt_o); end
            end
            if (c == 5) begin
                checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL simul_gnt1: got %b want 10", gnt_o); end
            end
            if (ack_o != '0) begin
                n_ack++;
                checks++;
                if (n_ack == 1 && (ack_o !== 2'b01 || c != 3 || rdata_o !== ref_mem[2])) begin
                    errors++; $display("FAIL simul_first: ack=%b cyc=%0d rdata=%h want 01/3/%h",
                                       ack_o, c, rdata_o, ref_mem[2]);
                end
                if (n_ack == 2 && (ack_o !== 2'b10 || c != 7 || rdata_o !== ref_mem[3])) begin
                    errors++; $display("FAIL simul_second: ack=%b cyc=%0d rdata=%h want 10/7/%h",
                                       ack_o, c, rdata_o, ref_mem[3]);
                end
                req = req & ~ack_o;
            end
        end
        ref_ptr = 0;
        checks++; if (n_ack != 2) begin errors++; $display("FAIL simul_count: got %0d want 2", n_ack); end
    endtask

    task automatic test_back_to_back();
        int n_ack = 0, last = 0, exp_m;
        logic [7:0] w [N];
        @(negedge clk);
        for (int m = 0; m < N; m++) begin
            w[m] = 8'($urandom_range(0, 63));
            set_req(m, 1'b0, {22'd0, w[m], 2'b00}, 32'd0);
        end
        for (int c = 1; c <= 60 && n_ack < 6; c++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                exp_m = rr_ref(req, ref_ptr);
                n_ack++;
                checks++; if (ack_o !== N'(1 << exp_m) || rdata_o !== ref_mem[w[exp_m]] ||
                              (n_ack > 1 && c - last != 4)) begin
                    errors++; $display("FAIL b2b_%0d: ack=%b rdata=%h gap=%0d want %b/%h/4", n_ack,
                                       ack_o, rdata_o, c - last, N'(1 << exp_m), ref_mem[w[exp_m]]);
                end
                last = c;
                ref_ptr = (exp_m + 1) % N;
                w[exp_m] = 8'($urandom_range(0, 63));
                addr[exp_m*32 +: 32] = {22'd0, w[exp_m], 2'b00};
            end
        end
        req = '0;
        checks++; if (n_ack != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", n_ack); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ack_cyc = 0, early = 0;
        @(negedge clk);
        set_req(0, 1'b0, 32'd32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (ack_o != '0) early++;
        checks++; if ({gnt_o, ack_o, busy_o, mem_ce_o, mem_we_o, rdata_o, mem_addr_o} !== '0) begin
            errors++; $display("FAIL midreset_outputs: gnt=%b ack=%b busy=%b ce=%b addr=%h want 0",
                               gnt_o, ack_o, busy_o, mem_ce_o, mem_addr_o);
        end
        rst = 1'b1;
        ref_ptr = 0;
        for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                ack_cyc = c;
                checks++; if (ack_o !== 2'b01 || rdata_o !== ref_mem[8]) begin
                    errors++; $display("FAIL midreset_ack: ack=%b rdata=%h want 01/%h", ack_o, rdata_o, ref_mem[8]);
                end
                req[0] = 1'b0;
            end
        end
        ref_ptr = 1;
        checks++; if (ack_cyc != 3 || early != 0) begin
            errors++; $display("FAIL midreset_latency: got %0d early=%0d want 3/0", ack_cyc, early);
        end
    endtask

    // Random request traffic; new requests appear only when a transaction is acked or
    // while nothing is pending, so the pending set is fixed between arbitration and ack.
    task automatic test_random();
        logic [N-1:0] pend = '0;
        bit          op_we [N];
        logic [7:0]  op_w [N];
        logic [31:0] op_d [N];
        int n_ack = 0, exp_cyc = -1, exp_m;
        @(negedge clk);
        for (int c = 1; c <= 2000 && n_ack < 40; c++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                exp_m = rr_ref(pend, ref_ptr);
                n_ack++;
                checks++;
                if (exp_m < 0 || ack_o !== N'(1 << exp_m) || c != exp_cyc) begin
                    errors++; $display("FAIL rand_ack_%0d: ack=%b cyc=%0d want master %0d cyc %0d",
                                       n_ack, ack_o, c, exp_m, exp_cyc);
                end else begin
                    checks++;
                    if (rdata_o !== (op_we[exp_m] ? 32'd0 : ref_mem[op_w[exp_m]])) begin
                        errors++; $display("FAIL rand_rdata_%0d: got %h want %h", n_ack, rdata_o,
                                           op_we[exp_m] ? 32'd0 : ref_mem[op_w[exp_m]]);
                    end
                    if (op_we[exp_m]) ref_mem[op_w[exp_m]] = op_d[exp_m];
                    pend[exp_m] = 1'b0;
                    req[exp_m]  = 1'b0;
                    ref_ptr     = (exp_m + 1) % N;
                end
            end
            if (ack_o != '0 || pend == '0) begin
                for (int m = 0; m < N; m++) begin
                    if (!pend[m] && $urandom_range(0, 1) == 1) begin
                        pend[m]  = 1'b1;
                        op_we[m] = 1'($urandom_range(0, 1));
                        op_w[m]  = 8'($urandom_range(0, 15));
                        op_d[m]  = $urandom;
                        set_req(m, op_we[m], {22'd0, op_w[m], 2'b00}, op_d[m]);
                    end
                end
                if (pend != '0) exp_cyc = (ack_o != '0) ? c + 4 : c + 3;
            end
        end
        req = '0;
        checks++; if (n_ack != 40) begin errors++; $display("FAIL rand_count: got %0d want 40", n_ack); end
        repeat (4) @(negedge clk);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int n_ack = 0;
        logic [N-1:0] exp;
        do_reset();
        lock = 2'b01;
        set_req(0, 1'b0, 32'd4, 32'd0);
        set_req(1, 1'b0, 32'd20, 32'd0);
        for (int c = 1; c <= 60 && n_ack < 4; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_hold_gnt: got %b want 01", gnt_o); end
            end
            if (ack_o != '0) begin
                n_ack++;
                exp = (n_ack <= 3) ? 2'b01 : 2'b10;
                checks++; if (ack_o !== exp) begin
                    errors++; $display("FAIL lock_ack_%0d: got %b want %b", n_ack, ack_o, exp);
                end
                if (n_ack == 3) begin lock = 2'b00; req[0] = 1'b0; end
                if (n_ack == 4) req[1] = 1'b0;
            end
        end
        checks++; if (n_ack != 4) begin errors++; $display("FAIL lock_count: got %0d want 4", n_ack); end
        ref_ptr = 0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = word_init(i);
        test_reset();
        test_single_read();
        test_write_readback();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
